// File: rtl/sum_result_collector.sv
// Result collector downstream of the 32-bit adder: valid/ready capture into a
// small FIFO, plus a saturating running total with a sticky overflow flag.
module sum_result_collector #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int ACC_WIDTH = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       clear,
  output logic [ACC_WIDTH-1:0]       acc,
  output logic                       acc_sat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {ACC_WIDTH{1'b1}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             push;
  logic             pop;
  logic [ACC_WIDTH:0] acc_sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic             sat_next;

  // Ready depends only on reset and registered occupancy, never on out_ready.
  assign in_ready  = rst_n & (count != CNT_FULL);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_sum  = {1'b0, acc} + {{(ACC_WIDTH+1-WIDTH){1'b0}}, in_sum};
    acc_next = acc;
    sat_next = acc_sat;
    if (acc_sum[ACC_WIDTH]) begin
      // Carry out of the top bit means the true sum exceeds the maximum;
      // this also covers acc already at max plus a nonzero in_sum.
      acc_next = ACC_MAX;
      sat_next = 1'b1;
    end else begin
      acc_next = acc_sum[ACC_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      acc     <= '0;
      acc_sat <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // clear takes priority over accumulating a same-cycle push.
      if (clear) begin
        acc     <= '0;
        acc_sat <= 1'b0;
      end else if (push) begin
        acc     <= acc_next;
        acc_sat <= sat_next;
      end
    end
  end

  // NOTE: the storage array is not reset; out_data is gated by count, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_sum;
  end

endmodule

// File: tb/tb_sum_result_collector.sv
// Directed, table-driven bench for sum_result_collector with hand-written
// sequences for pointer wrap, saturation and mid-operation reset.
module tb_sum_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        clear;
  logic [39:0] acc;
  logic        acc_sat;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  sum_result_collector #(.WIDTH(32), .DEPTH(4), .ACC_WIDTH(40)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .clear     (clear),
    .acc       (acc),
    .acc_sat   (acc_sat),
    .count     (count)
  );

  typedef struct {
    logic        iv;
    logic [31:0] sum;
    logic        ordy;
    logic        clr;
    logic [2:0]  cnt;
    logic        ov;
    logic [31:0] od;
    logic [39:0] acc;
    logic        sat;
    logic        ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic iv, logic [31:0] sum, logic ordy, logic clr,
                             logic [2:0] cnt, logic ov, logic [31:0] od,
                             logic [39:0] a, logic sat, logic ir);
    vec_t r;
    r.iv = iv; r.sum = sum; r.ordy = ordy; r.clr = clr;
    r.cnt = cnt; r.ov = ov; r.od = od; r.acc = a; r.sat = sat; r.ir = ir;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] sum, input logic ordy, input logic clr);
    in_valid  = iv;
    in_sum    = sum;
    out_ready = ordy;
    clear     = clr;
  endtask

  task automatic check_state(input string tag, input logic [2:0] cnt, input logic [31:0] od,
                             input logic [39:0] a, input logic sat);
    check({tag, ".count"},     64'(count),     64'(cnt));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(cnt != 0));
    check({tag, ".out_data"},  64'(out_data),  64'(od));
    check({tag, ".acc"},       64'(acc),       64'(a));
    check({tag, ".acc_sat"},   64'(acc_sat),   64'(sat));
  endtask

  int          q[$];
  logic [31:0] exp_head;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check_state("rst", 3'd0, 32'd0, 40'd0, 1'b0);

    // Columns: in_valid, in_sum, out_ready, clear | count, out_valid, out_data, acc, acc_sat, in_ready
    vecs.push_back(v(1, 5,  0, 0,  1, 1, 5,  12'd5,  0, 1));
    vecs.push_back(v(1, 7,  0, 0,  2, 1, 5,  40'd12, 0, 1));
    vecs.push_back(v(0, 0,  1, 0,  1, 1, 7,  40'd12, 0, 1));
    vecs.push_back(v(0, 0,  1, 0,  0, 0, 0,  40'd12, 0, 1));
    vecs.push_back(v(1, 1,  0, 0,  1, 1, 1,  40'd13, 0, 1));
    vecs.push_back(v(1, 2,  0, 0,  2, 1, 1,  40'd15, 0, 1));
    vecs.push_back(v(1, 3,  0, 0,  3, 1, 1,  40'd18, 0, 1));
    vecs.push_back(v(1, 4,  0, 0,  4, 1, 1,  40'd22, 0, 0));
    vecs.push_back(v(1, 50, 0, 0,  4, 1, 1,  40'd22, 0, 0));
    vecs.push_back(v(1, 50, 1, 0,  3, 1, 2,  40'd22, 0, 1));
    vecs.push_back(v(1, 50, 0, 0,  4, 1, 2,  40'd72, 0, 0));
    vecs.push_back(v(0, 0,  1, 0,  3, 1, 3,  40'd72, 0, 1));
    vecs.push_back(v(0, 0,  1, 0,  2, 1, 4,  40'd72, 0, 1));
    vecs.push_back(v(0, 0,  1, 0,  1, 1, 50, 40'd72, 0, 1));
    vecs.push_back(v(0, 0,  1, 0,  0, 0, 0,  40'd72, 0, 1));
    vecs.push_back(v(0, 0,  1, 0,  0, 0, 0,  40'd72, 0, 1));
    vecs.push_back(v(1, 9,  0, 1,  1, 1, 9,  40'd0,  0, 1));
    vecs.push_back(v(1, 3,  0, 0,  2, 1, 9,  40'd3,  0, 1));
    vecs.push_back(v(0, 0,  1, 0,  1, 1, 3,  40'd3,  0, 1));
    vecs.push_back(v(0, 0,  1, 0,  0, 0, 0,  40'd3,  0, 1));

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].iv, vecs[i].sum, vecs[i].ordy, vecs[i].clr);
      tick();
      check_state(tag, vecs[i].cnt, vecs[i].od, vecs[i].acc, vecs[i].sat);
      check({tag, ".in_ready"}, 64'(in_ready), 64'(vecs[i].ir));
    end

    // Steady push+pop at count=2 across several pointer wraps.
    drive(1'b1, 32'd100, 1'b0, 1'b0); tick(); q.push_back(100);
    drive(1'b1, 32'd101, 1'b0, 1'b0); tick(); q.push_back(101);
    check("wrap.fill", 64'(count), 64'd2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(102 + i), 1'b1, 1'b0);
      exp_head = 32'(q.pop_front());
      check($sformatf("wrap%0d.head", i), 64'(out_data), 64'(exp_head));
      q.push_back(102 + i);
      tick();
      check($sformatf("wrap%0d.count", i), 64'(count), 64'd2);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      exp_head = 32'(q.pop_front());
      check($sformatf("drain%0d.head", i), 64'(out_data), 64'(exp_head));
      tick();
    end
    check("drain.count", 64'(count), 64'd0);

    // Saturation: 256 pushes of all-ones stay just below max, the 257th clamps.
    drive(1'b0, 32'd0, 1'b0, 1'b1); tick();
    check("sat.clear", 64'(acc), 64'd0);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      tick();
    end
    check("sat256.acc", 64'(acc), 64'hFF_FFFF_FF00);
    check("sat256.sat", 64'(acc_sat), 64'd0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0); tick();
    check("sat257.acc", 64'(acc), 64'hFF_FFFF_FFFF);
    check("sat257.sat", 64'(acc_sat), 64'd1);
    drive(1'b1, 32'd1, 1'b1, 1'b0); tick();
    check("satmax.acc", 64'(acc), 64'hFF_FFFF_FFFF);
    check("satmax.sat", 64'(acc_sat), 64'd1);
    drive(1'b0, 32'd0, 1'b1, 1'b1); tick();
    check("satclr.acc", 64'(acc), 64'd0);
    check("satclr.sat", 64'(acc_sat), 64'd0);
    check("satclr.count", 64'(count), 64'd0);

    // Mid-operation reset with count=3 and acc=100.
    drive(1'b1, 32'd40, 1'b0, 1'b0); tick();
    drive(1'b1, 32'd30, 1'b0, 1'b0); tick();
    drive(1'b1, 32'd30, 1'b0, 1'b0); tick();
    check_state("pre_rst", 3'd3, 32'd40, 40'd100, 1'b0);
    drive(1'b1, 32'd77, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst.in_ready", 64'(in_ready), 64'd0);
    tick();
    check_state("post_rst", 3'd0, 32'd0, 40'd0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 32'd11, 1'b0, 1'b0);
    #1;
    check("first.in_ready", 64'(in_ready), 64'd1);
    tick();
    check_state("first_push", 3'd1, 32'd11, 40'd11, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
